// File: rtl/boot_ctrl.sv
// boot_ctrl: boot and debug controller for the 8-bit microcpu system.
//
// While the CPU is halted the host owns the memory bus and can set an
// address pointer, write bytes and read them back. A run command releases
// the CPU from reset and hands it the bus. A halt command waits for any CPU
// store in flight to finish (DRAIN) before taking the bus back.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   host_valid/cmd/data/ready     host command port (0 addr, 1 wr, 2 rd, 3 run/halt)
//   rsp_valid, rsp_data           read-back byte, one-cycle pulse
//   running, cpu_rst              CPU owns the bus / CPU reset (both registered)
//   cpu_write/read/address/dout   CPU bus master side
//   cpu_din                       CPU read data (mem_rdata)
//   mem_write/read/address/wdata  memory bus
//   mem_rdata                     memory read data (combinational on mem_address)
module boot_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    input  logic [1:0]        host_cmd,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              running,
    output logic              cpu_rst,
    input  logic              cpu_write,
    input  logic              cpu_read,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        HALT,
        WR,
        RD,
        RUN,
        DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              running_q, running_d;
    logic              accept;

    assign host_ready = (state_q == HALT) || (state_q == RUN);
    assign accept     = host_valid && host_ready;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign cpu_rst    = cpu_rst_q;
    assign running    = running_q;
    assign cpu_din    = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HALT;
            ptr_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cpu_rst_q   <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cpu_rst_q   <= cpu_rst_d;
            running_q   <= running_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            HALT: begin
                if (accept) begin
                    case (host_cmd)
                        2'd0: ptr_d = ADDR_W'(host_data);
                        2'd1: begin
                            wdata_d = host_data;
                            state_d = WR;
                        end
                        2'd2: state_d = RD;
                        default: begin
                            if (host_data[0]) state_d = RUN;
                        end
                    endcase
                end
            end
            WR: begin
                ptr_d   = ptr_q + 1'b1;
                state_d = HALT;
            end
            RD: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_rdata;
                ptr_d       = ptr_q + 1'b1;
                state_d     = HALT;
            end
            RUN: begin
                // Commands 0..2 are accepted but have no effect while running.
                if (accept && host_cmd == 2'd3 && !host_data[0]) begin
                    state_d = cpu_write ? DRAIN : HALT;
                end
            end
            DRAIN: begin
                if (!cpu_write) state_d = HALT;
            end
            default: state_d = HALT;
        endcase

        // Derived from the next state so both flops change on the same edge
        // as the state register.
        running_d = (state_d == RUN) || (state_d == DRAIN);
        cpu_rst_d = !running_d;
    end

    // Bus mux: select comes from registered state only, so a host strobe
    // and a CPU strobe can never be driven in the same cycle.
    always_comb begin
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        mem_address = ptr_q;
        mem_wdata   = '0;
        case (state_q)
            WR: begin
                mem_write = 1'b1;
                mem_wdata = wdata_q;
            end
            RD: mem_read = 1'b1;
            RUN, DRAIN: begin
                mem_write   = cpu_write;
                mem_read    = cpu_read;
                mem_address = cpu_address;
                mem_wdata   = cpu_dout;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Boot and debug controller for the 8-bit microcpu system. It sits between the CPU, a host byte port and the shared program/data memory. While the CPU is halted, the host loads and reads back memory through it. On a run command it holds the CPU in reset, then releases it and hands the memory bus to the CPU.

## Interface
Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory/host data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- host_valid  in  1  host command present.
- host_cmd  in  2  0 = set address, 1 = write byte, 2 = read byte, 3 = run/halt.
- host_data  in  DATA_W  command argument.
- host_ready  out  1  block accepts a command this cycle.
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rsp_data  out  DATA_W  read-back byte.
- running  out  1  CPU owns the bus.
- cpu_rst  out  1  reset to CPU, registered.
- cpu_write, cpu_read  in  1  CPU bus strobes.
- cpu_address  in  ADDR_W  CPU bus address.
- cpu_dout  in  DATA_W  CPU bus write data.
- cpu_din  out  DATA_W  equals mem_rdata at all times.
- mem_write, mem_read  out  1  memory strobes.
- mem_address  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, combinational w.r.t. mem_address.

## Operation
- States: HALT, WR, RD, RUN, DRAIN.
- Address pointer `ptr` (ADDR_W bits). Increments after every WR and RD and wraps from 0xFF to 0x00.
- A command is accepted on an edge where host_valid && host_ready.
- host_ready is 1 in HALT and RUN and 0 in WR, RD and DRAIN.

HALT (cpu_rst = 1, running = 0, host owns the bus):
- cmd 0: ptr = host_data; stay in HALT.
- cmd 1: latch host_data; go to WR.
- cmd 2: go to RD.
- cmd 3 with host_data[0] = 1: go to RUN.
- cmd 3 with host_data[0] = 0: no-op.

WR:
- mem_address = ptr, mem_wdata = latched byte, mem_write = 1.
- After one cycle: ptr++, return to HALT.

RD:
- mem_address = ptr, mem_read = 1.
- After one cycle: rsp_data = mem_rdata, rsp_valid = 1 for one cycle, ptr++, return to HALT.

RUN (cpu_rst = 0, running = 1):
- mem_* pass through cpu_* combinationally.
- cmd 3 with host_data[0] = 0: go to HALT if cpu_write = 0, else go to DRAIN.
- cmd 3 with host_data[0] = 1: no-op.
- cmds 0, 1 and 2 are accepted and discarded. There is no rsp_valid and ptr is unchanged.

DRAIN:
- Bus stays with the CPU and cpu_rst stays 0.
- Go to HALT on the first edge where cpu_write = 0.

Bus outputs outside WR, RD, RUN and DRAIN:
- mem_write = 0, mem_read = 0, mem_address = ptr, mem_wdata = 0.

No memory strobe is ever driven by both host and CPU in the same cycle.

## Timing
Reset values (asynchronous, while rst = 1):
- State HALT, ptr = 0, cpu_rst = 1, running = 0.
- host_ready = 1, rsp_valid = 0, rsp_data = 0, mem_write = 0, mem_read = 0.

Reset asserted mid-WR, RD or DRAIN:
- The operation is abandoned immediately and mem_write drops the same instant.

Latencies, counted from the accept edge:
- Write: mem_write is high for exactly the next cycle. host_ready is 1 again one cycle later, so a write costs 2 cycles.
- Read: mem_read is high the next cycle. rsp_valid and host_ready are high the cycle after that.
- Run: cpu_rst = 0 and running = 1 from the next cycle.
- Halt: cpu_rst = 1 and running = 0 the cycle after acceptance. If cpu_write was 1, they follow the edge that sees cpu_write = 0.

Other rules:
- cpu_rst, running and rsp_valid are registered outputs; the mem_* mux select comes from registered state only.
- host_valid may stay high while host_ready = 0. The command is taken on the first ready edge and held commands are never dropped.

## Test plan
- Reset mid-WR (rst pulsed while mem_write = 1) -> mem_write = 0 immediately; cpu_rst = 1, ptr = 0, host_ready = 1.
- cmd0 0x10, then cmd1 0xA5, then cmd1 0x3C -> mem writes 0xA5 @0x10 and 0x3C @0x11, each strobe exactly one cycle; ptr = 0x12.
- cmd0 0x10, then cmd2, then cmd2 -> rsp_valid pulses with rsp_data 0xA5 then 0x3C, two cycles after each accept.
- cmd0 0xFF, then cmd1 0x77, then cmd2 -> write lands @0xFF; the read hits @0x00, showing the wrap.
- cmd3 0x01 -> cpu_rst falls the next cycle; a CPU store of 0x42 to 0x80 appears on mem_*. A cmd1 sent while running causes no memory write.
- cmd3 0x00 issued while cpu_write = 1 for 2 cycles -> DRAIN; cpu_rst rises only after cpu_write falls; the CPU store completes intact.
